// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the memory access unit: access-size encodings,
// FSM state type, default timeout and the alignment-check helper.
package mem_access_pkg;

  // Access size as carried on req_size.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } mem_size_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_e;

  // Maximum number of ACCESS cycles spent waiting for mem_ack.
  localparam int unsigned WAIT_LIMIT_DEFAULT = 64;

  // A request is misaligned when its size is illegal, or when the low
  // address bits do not match the natural alignment of the access.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      SIZE_WORD: mis = |offset;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// load_extender
// Combinational lane select and sign/zero extension of a loaded word.
// Ports:
//   rdata_i  [31:0] raw word returned by memory
//   offset_i [1:0]  byte offset within the word (addr[1:0])
//   size_i   [1:0]  access size (byte/half/word)
//   sign_i          1 = sign-extend, 0 = zero-extend
//   data_o   [31:0] extended load result
module load_extender
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Little-endian: byte lane n sits in bits [8n+7:8n].
    byte_sel = rdata_i[7:0];
    case (offset_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    // Halfwords are always 2-byte aligned here, so only offset bit 1 matters.
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Executes one load/store at a time against a word-wide memory port.
// Requests are accepted in IDLE, checked for alignment, issued to memory
// in ACCESS (held stable until mem_ack or timeout) and answered with a
// single-cycle response in RESP.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_we/size/sign/addr/wdata/rt request fields
//   mem_en/wen/addr/wdata          memory request (word aligned, lane replicated)
//   mem_rdata/mem_ack              memory read data and completion
//   resp_valid/rdata/rt/err        one-cycle response; err = misaligned or timeout
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rt,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rt,
  output logic        resp_err
);

  // The counter only needs to reach WAIT_LIMIT-1: the last waiting cycle
  // is recognised by comparison rather than by counting past it.
  localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  mau_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        we_q,    we_d;
  logic [1:0]  size_q,  size_d;
  logic        sign_q,  sign_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rt_q,    rt_d;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;

  logic [31:0] load_data;
  logic [3:0]  store_wen;
  logic [31:0] store_wdata;

  load_extender u_load_extender (
    .rdata_i  (mem_rdata),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .sign_i   (sign_q),
    .data_o   (load_data)
  );

  // Byte enables and replicated store data derived from the captured request.
  always_comb begin
    store_wen   = 4'b1111;
    store_wdata = wdata_q;
    case (size_q)
      SIZE_BYTE: begin
        store_wen   = 4'b0001 << addr_q[1:0];
        store_wdata = {4{wdata_q[7:0]}};
      end
      SIZE_HALF: begin
        store_wen   = 4'b0011 << addr_q[1:0];
        store_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        store_wen   = 4'b1111;
        store_wdata = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rt_q    <= 5'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rt_q    <= rt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rt_d    = rt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    // Gating with resetn keeps req_ready low while reset is held, even
    // though the state register is already IDLE.
    req_ready  = (state_q == ST_IDLE) && resetn;
    mem_en     = 1'b0;
    mem_wen    = 4'b0000;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_rt    = 5'd0;
    resp_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sign_d  = req_sign;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rt_d    = req_rt;
          cnt_d   = '0;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            // Answer straight away without touching memory.
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wen   = we_q ? store_wen : 4'b0000;
        mem_wdata = store_wdata;
        // An ack on the last allowed cycle wins over the timeout.
        if (mem_ack) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : load_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_rt    = rt_q;
        resp_err   = err_q;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rt = 5'd0;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rt;
  logic        resp_err;

  mem_access_unit #(.WAIT_LIMIT(WL)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rt     (req_rt),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_rt    (resp_rt),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rt;
    logic [31:0] rdata;
    int          ack_dly;   // cycles in ACCESS before ack; -1 = never
    logic        exp_mem;
    logic [3:0]  exp_wen;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [4:0]  rt;
  } resp_t;

  vec_t  vecs[15];
  resp_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic vec_t mk(logic we, logic [1:0] size, logic sign,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic [4:0] rt, logic [31:0] rdata, int dly,
                              logic exp_mem, logic [3:0] wen,
                              logic [31:0] wd, logic [31:0] rd, logic err);
    vec_t v;
    v.we = we; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.rt = rt; v.rdata = rdata; v.ack_dly = dly; v.exp_mem = exp_mem;
    v.exp_wen = wen; v.exp_maddr = {addr[31:2], 2'b00}; v.exp_wdata = wd;
    v.exp_rdata = rd; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    chk($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_sign = v.sign;
    req_addr = v.addr; req_wdata = v.wdata; req_rt = v.rt;
    exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, rt: v.rt});
    $display("req %0d: we=%0d size=%0d sign=%0d addr=0x%08h wdata=0x%08h rt=%0d",
             idx, v.we, v.size, v.sign, v.addr, v.wdata, v.rt);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!v.exp_mem) begin
      @(negedge clk);
      chk($sformatf("v%0d mem_en idle", idx), {31'd0, mem_en}, 32'd0);
      chk($sformatf("v%0d resp_valid", idx), {31'd0, resp_valid}, 32'd1);
    end else begin
      n = (v.ack_dly < 0) ? WL : v.ack_dly + 1;
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d mem_en c%0d", idx, k), {31'd0, mem_en}, 32'd1);
        chk($sformatf("v%0d mem_addr c%0d", idx, k), mem_addr, v.exp_maddr);
        chk($sformatf("v%0d mem_wen c%0d", idx, k), {28'd0, mem_wen}, {28'd0, v.exp_wen});
        chk($sformatf("v%0d mem_wdata c%0d", idx, k), mem_wdata, v.exp_wdata);
        chk($sformatf("v%0d resp_valid early c%0d", idx, k), {31'd0, resp_valid}, 32'd0);
        if (k == v.ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      @(negedge clk);
      chk($sformatf("v%0d mem_en after", idx), {31'd0, mem_en}, 32'd0);
      chk($sformatf("v%0d resp_valid", idx), {31'd0, resp_valid}, 32'd1);
    end
    for (int t = 0; t < 8 && exp_q.size() != 0; t++) @(negedge clk);
    chk($sformatf("v%0d resp drained", idx), exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin : main
    vecs[0]  = mk(1, 2'd0, 0, 32'h1003, 32'h000000A5, 5'd3,  32'h0,        1, 1, 4'b1000, 32'hA5A5A5A5, 32'h0,        0);
    vecs[1]  = mk(0, 2'd0, 1, 32'h2002, 32'h0,        5'd4,  32'h12805634, 0, 1, 4'b0000, 32'h0,        32'hFFFFFF80, 0);
    vecs[2]  = mk(0, 2'd0, 0, 32'h2002, 32'h0,        5'd5,  32'h12805634, 2, 1, 4'b0000, 32'h0,        32'h00000080, 0);
    vecs[3]  = mk(0, 2'd1, 1, 32'h2001, 32'h0,        5'd6,  32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1);
    vecs[4]  = mk(0, 2'd2, 0, 32'h3000, 32'h0,        5'd7,  32'h11111111,-1, 1, 4'b0000, 32'h0,        32'h0,        1);
    vecs[5]  = mk(0, 2'd2, 0, 32'h3004, 32'h0,        5'd8,  32'hDEADBEEF, 3, 1, 4'b0000, 32'h0,        32'hDEADBEEF, 0);
    vecs[6]  = mk(1, 2'd1, 0, 32'h4002, 32'h1234BEEF, 5'd9,  32'h0,        0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0);
    vecs[7]  = mk(1, 2'd2, 0, 32'h5000, 32'hCAFEF00D, 5'd10, 32'h12345678, 1, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        0);
    vecs[8]  = mk(0, 2'd1, 1, 32'h6002, 32'h0,        5'd11, 32'h80017FFF, 0, 1, 4'b0000, 32'h0,        32'hFFFF8001, 0);
    vecs[9]  = mk(0, 2'd1, 0, 32'h6000, 32'h0,        5'd12, 32'h80017FFF, 1, 1, 4'b0000, 32'h0,        32'h00007FFF, 0);
    vecs[10] = mk(0, 2'd3, 0, 32'h7000, 32'h0,        5'd13, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1);
    vecs[11] = mk(1, 2'd2, 0, 32'h5002, 32'hFFFFFFFF, 5'd14, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1);
    vecs[12] = mk(0, 2'd0, 0, 32'h2001, 32'h0,        5'd15, 32'h12805634, 0, 1, 4'b0000, 32'h0,        32'h00000056, 0);
    vecs[13] = mk(0, 2'd1, 1, 32'h6000, 32'h0,        5'd16, 32'h1234F00D, 0, 1, 4'b0000, 32'h0,        32'hFFFFF00D, 0);
    vecs[14] = mk(1, 2'd0, 0, 32'h1000, 32'h1234567F, 5'd31, 32'h0,        0, 1, 4'b0001, 32'h7F7F7F7F, 32'h0,        0);

    // Response monitor: every resp_valid cycle must match the oldest
    // expected response; an unexpected response is a failure.
    fork
      forever begin
        @(negedge clk);
        if (resp_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected resp: got rt=%0d rdata=0x%08h err=%0d required none",
                     resp_rt, resp_rdata, resp_err);
          end else begin
            resp_t e;
            e = exp_q.pop_front();
            $display("resp: rt=%0d rdata=0x%08h err=%0d", resp_rt, resp_rdata, resp_err);
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            chk("resp_rt", {27'd0, resp_rt}, {27'd0, e.rt});
          end
        end
      end
    join_none

    // Reset state while resetn is held low.
    #12;
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset mem_en", {31'd0, mem_en}, 32'd0);
    chk("reset mem_wen", {28'd0, mem_wen}, 32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    @(negedge clk); #2;
    resetn = 1'b1;

    // Stray mem_ack while IDLE must be ignored.
    @(negedge clk);
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray ack mem_en", {31'd0, mem_en}, 32'd0);
    chk("stray ack req_ready", {31'd0, req_ready}, 32'd1);
    mem_ack = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Reset asserted mid-ACCESS: mem_en drops at once, no response follows.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0;
    req_addr = 32'h8000; req_wdata = 32'd0; req_rt = 5'd20;
    $display("req abort: LW addr=0x00008000 rt=20");
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort mem_en before", {31'd0, mem_en}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort mem_en", {31'd0, mem_en}, 32'd0);
    chk("abort req_ready", {31'd0, req_ready}, 32'd0);
    chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    #2;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(100, vecs[1]);
    run_vec(101, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 64, meaning the maximum number of ACCESS cycles without mem_ack before a timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1 bit: 1 for store, 0 for load.
REQ-007 SHALL have port req_size, input, 2 bits: 0 byte, 1 half, 2 word, 3 illegal.
REQ-008 SHALL have port req_sign, input, 1 bit: sign-extend loads.
REQ-009 SHALL have port req_addr, input, 32 bits: effective address (ALU result).
REQ-010 SHALL have port req_wdata, input, 32 bits: store data (rt content).
REQ-011 SHALL have port req_rt, input, 5 bits: load destination register.
REQ-012 SHALL have port mem_en, output, 1 bit: memory request.
REQ-013 SHALL have port mem_wen, output, 4 bits: byte write enables.
REQ-014 SHALL have port mem_addr, output, 32 bits: word-aligned address.
REQ-015 SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-016 SHALL have port mem_rdata, input, 32 bits: read word.
REQ-017 SHALL have port mem_ack, input, 1 bit: memory completion.
REQ-018 SHALL have output ports resp_valid (1 bit), resp_rdata (32 bits), resp_rt (5 bits) and resp_err (1 bit): the response, with resp_err indicating misalignment or timeout.

Function
REQ-019 SHALL implement FSM IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL capture we/size/sign/addr/wdata/rt on req_valid && req_ready.
REQ-021 SHALL treat as misaligned: size 3; half with addr[0]=1; word with addr[1:0]!=0.
REQ-022 SHALL, on a misaligned request, go IDLE->RESP with resp_err=1, never asserting mem_en.
REQ-023 SHALL otherwise go IDLE->ACCESS and hold mem_en=1 and all mem_* outputs stable until mem_ack or timeout.
REQ-024 SHALL drive mem_addr = {addr[31:2],2'b00}.
REQ-025 SHALL drive mem_wen, zero for loads; for stores: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111 (little-endian).
REQ-026 SHALL drive mem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-027 SHALL, on mem_ack in ACCESS, register the load result (lane select by addr[1:0], sign/zero extend per req_sign) and go to RESP; stores return resp_rdata=0.
REQ-028 SHALL count ACCESS cycles; after WAIT_LIMIT cycles with no mem_ack, go to RESP with resp_err=1, resp_rdata=0, and drop mem_en.
REQ-029 SHALL treat mem_ack coinciding with the final timeout cycle as success.
REQ-030 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; resp_rt = captured rt.
REQ-031 SHALL ignore mem_ack outside ACCESS.
REQ-032 SHALL have latency: accept at edge N, mem_en from N+1, resp_valid the cycle after the ack edge; minimum 3 cycles per access, no overlap.

Reset
REQ-033 SHALL, while resetn=0, set state IDLE, counter 0, and all outputs 0 (req_ready gated to 0), taking effect immediately and independent of clk.
REQ-034 SHALL abandon any in-flight access when reset is asserted mid-operation; no response is issued for it.
REQ-035 SHALL permit req_ready=1 from the first clk edge after resetn rises.

Structure
REQ-036 SHALL place size encodings, the FSM state typedef and the WAIT_LIMIT default in shared package mem_access_pkg.
REQ-037 SHALL implement lane select and extension in one combinational sub-module, load_extender.

Verification
REQ-038 SHALL cover: SB addr 0x1003, wdata 0x000000A5 -> mem_wen 4'b1000, mem_addr 0x1000, mem_wdata 0xA5A5A5A5; resp_err 0.
REQ-039 SHALL cover: LB signed addr 0x2002, mem_rdata 0x12805634 -> resp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-040 SHALL cover: LH addr 0x2001 -> resp_err 1, mem_en never asserted, resp_valid after 1 cycle.
REQ-041 SHALL cover: LW with mem_ack held low, WAIT_LIMIT=4 -> mem_en high 4 cycles, then resp_err 1.
REQ-042 SHALL cover: resetn pulled low during ACCESS -> mem_en 0 immediately, no resp_valid; next request served normally.
